// File: rtl/hex_display_driver.sv
// Multi-digit hex seven-segment driver with value register, inc/dec wrap and blink.
// Define HEX_LZB_EN to enable leading-zero blanking.
module hex_display_driver #(
  parameter int DIGITS     = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  inc_i,
  input  logic                  dec_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic [DIGITS-1:0]     blink_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic                  wrap_o,
  output logic [7*DIGITS-1:0]   hex_o
);

  localparam int VW = 4 * DIGITS;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CMAX = CW'(BLINK_DIV - 1);
  localparam logic [6:0] OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [VW-1:0]       value_q, value_d;
  logic                wrap_q, wrap_d;
  logic [CW-1:0]       cnt_q;
  logic                phase_q;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic [3:0]          dig;
  logic                dig_off;
  logic [6:0]          code;
`ifdef HEX_LZB_EN
  logic                lead;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    unique case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // load wins; simultaneous inc and dec cancel out
  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      value_d = value_i;
    end else if (inc_i && !dec_i) begin
      value_d = value_q + 1'b1;
      wrap_d  = (value_q == '1);
    end else if (dec_i && !inc_i) begin
      value_d = value_q - 1'b1;
      wrap_d  = (value_q == '0);
    end
  end

  always_comb begin
    hex_d   = '0;
    dig     = '0;
    dig_off = 1'b0;
    code    = '0;
`ifdef HEX_LZB_EN
    lead    = 1'b1;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dig     = value_q[4*k +: 4];
      dig_off = blank_i[k] | (blink_i[k] & phase_q);
`ifdef HEX_LZB_EN
      lead = lead & (dig == 4'h0);
      if (k != 0) dig_off = dig_off | lead;
`endif
      code = ACTIVE_LOW ? seg7(dig) : ~seg7(dig);
      hex_d[7*k +: 7] = dig_off ? OFF : code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      hex_q   <= {DIGITS{OFF}};
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
      hex_q   <= hex_d;
      if (cnt_q == CMAX) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign value_o = value_q;
  assign wrap_o  = wrap_q;
  assign hex_o   = hex_q;

endmodule
